// File: rtl/arbitro_rr_pkg.sv
// arbitro_rr_pkg -- shared definitions for the round-robin arbiter.
//   estado_t  : arbiter FSM states (OCIOSO = no grant, CONCEDIDO = one source granted)
//   N_FONTES  : number of request sources
//   IDX_W     : width of a source index
//   busca_rr  : round-robin search over the request vector starting at a pointer
package arbitro_rr_pkg;

  localparam int N_FONTES = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [0:0] {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } busca_t;

  // Returns the first requesting source at or after ptr, wrapping 7 -> 0.
  // The loop runs from the farthest offset down to offset 0 so that the
  // closest requester is the last one written and therefore wins.
  function automatic busca_t busca_rr(input logic [N_FONTES-1:0] req,
                                      input logic [IDX_W-1:0]    ptr);
    busca_t           r;
    logic [IDX_W-1:0] cand;
    r = '0;
    for (int k = N_FONTES - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arbitro_rr_mux8_4b.sv
// mux8_4b -- combinational 8:1 multiplexer of 4-bit data words.
//   sel    : index of the selected input
//   i0..i7 : data inputs
//   y      : selected data word
module mux8_4b
  import arbitro_rr_pkg::*;
(
  input  logic [IDX_W-1:0] sel,
  input  logic [3:0]       i0,
  input  logic [3:0]       i1,
  input  logic [3:0]       i2,
  input  logic [3:0]       i3,
  input  logic [3:0]       i4,
  input  logic [3:0]       i5,
  input  logic [3:0]       i6,
  input  logic [3:0]       i7,
  output logic [3:0]       y
);

  always_comb begin
    y = 4'b0000;
    case (sel)
      3'd0: y = i0;
      3'd1: y = i1;
      3'd2: y = i2;
      3'd3: y = i3;
      3'd4: y = i4;
      3'd5: y = i5;
      3'd6: y = i6;
      3'd7: y = i7;
      default: y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr -- 8-source round-robin arbiter with a per-grant time limit.
//   clock      : single clock, rising edge
//   reset      : synchronous active-high reset
//   REQ[7:0]   : request of each source
//   S0..S7     : 4-bit data of each source
//   GNT[7:0]   : registered one-hot grant, zero when idle
//   SEL[2:0]   : registered index of the granted source (held while idle)
//   VALIDO     : registered, high while a grant is active
//   SAIDA[3:0] : data of the granted source, zero when idle
//   ORIGEM[2:0]: SEL while VALIDO, zero otherwise
// A source keeps the grant for at most TEMPO_MAX consecutive cycles (1..8).
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int TEMPO_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_FONTES-1:0] REQ,
  input  logic [3:0]          S0,
  input  logic [3:0]          S1,
  input  logic [3:0]          S2,
  input  logic [3:0]          S3,
  input  logic [3:0]          S4,
  input  logic [3:0]          S5,
  input  logic [3:0]          S6,
  input  logic [3:0]          S7,
  output logic [N_FONTES-1:0] GNT,
  output logic [IDX_W-1:0]    SEL,
  output logic                VALIDO,
  output logic [3:0]          SAIDA,
  output logic [IDX_W-1:0]    ORIGEM
);

  localparam logic [3:0] TEMPO_LIM = 4'(TEMPO_MAX);

  estado_t          estado;
  logic [IDX_W-1:0] ptr;
  logic [3:0]       cont;

  logic [IDX_W-1:0] ptr_busca;
  logic             liberar;
  busca_t           res;
  logic [3:0]       dado_sel;

  // On a release the pointer moves past the releasing source in the same
  // edge, so the search already uses SEL+1 instead of the stored pointer.
  // When idle the stored pointer is used; it already equals the last SEL+1.
  always_comb begin
    liberar   = 1'b0;
    ptr_busca = ptr;
    if (estado == CONCEDIDO) begin
      ptr_busca = SEL + 3'd1;
      liberar   = !REQ[SEL] || (cont == TEMPO_LIM);
    end
    res = busca_rr(REQ, ptr_busca);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      ptr    <= '0;
      cont   <= '0;
      GNT    <= '0;
      SEL    <= '0;
      VALIDO <= 1'b0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (res.found) begin
            estado <= CONCEDIDO;
            SEL    <= res.idx;
            GNT    <= N_FONTES'(1) << res.idx;
            VALIDO <= 1'b1;
            cont   <= 4'd1;
          end else begin
            GNT    <= '0;
            VALIDO <= 1'b0;
          end
        end
        CONCEDIDO: begin
          if (liberar) begin
            ptr <= ptr_busca;
            // Re-arbitrate at the release edge: no idle bubble when
            // someone (possibly the same source) is still requesting.
            if (res.found) begin
              SEL  <= res.idx;
              GNT  <= N_FONTES'(1) << res.idx;
              cont <= 4'd1;
            end else begin
              estado <= OCIOSO;
              GNT    <= '0;
              VALIDO <= 1'b0;
              cont   <= '0;
            end
          end else begin
            cont <= cont + 4'd1;
          end
        end
        default: begin
          estado <= OCIOSO;
          GNT    <= '0;
          VALIDO <= 1'b0;
        end
      endcase
    end
  end

  mux8_4b u_mux (
    .sel (SEL),
    .i0  (S0),
    .i1  (S1),
    .i2  (S2),
    .i3  (S3),
    .i4  (S4),
    .i5  (S5),
    .i6  (S6),
    .i7  (S7),
    .y   (dado_sel)
  );

  assign SAIDA  = VALIDO ? dado_sel : 4'b0000;
  assign ORIGEM = VALIDO ? SEL : '0;

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr -- self-checking bench for arbitro_rr.
// Two instances share the inputs: dut_a with TEMPO_MAX=4 and dut_b with
// TEMPO_MAX=2. A behavioural model per instance predicts every output.
module tb_arbitro_rr;

  logic       clock;
  logic       reset;
  logic [7:0] req;
  logic [3:0] s [8];

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b, org_a, org_b;
  logic       val_a, val_b;
  logic [3:0] sai_a, sai_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit valido;
    int sel;
    int ptr;
    int cont;
  } mstate_t;

  mstate_t m_a = '{0, 0, 0, 0};
  mstate_t m_b = '{0, 0, 0, 0};

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       valido;
    logic [2:0] sel;
  } vetor_t;

  arbitro_rr #(.TEMPO_MAX(4)) dut_a (
    .clock(clock), .reset(reset), .REQ(req),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]),
    .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
    .GNT(gnt_a), .SEL(sel_a), .VALIDO(val_a), .SAIDA(sai_a), .ORIGEM(org_a)
  );

  arbitro_rr #(.TEMPO_MAX(2)) dut_b (
    .clock(clock), .reset(reset), .REQ(req),
    .S0(s[0]), .S1(s[1]), .S2(s[2]), .S3(s[3]),
    .S4(s[4]), .S5(s[5]), .S6(s[6]), .S7(s[7]),
    .GNT(gnt_b), .SEL(sel_b), .VALIDO(val_b), .SAIDA(sai_b), .ORIGEM(org_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // First requester at or after ptr, modulo 8; -1 when nobody requests.
  function automatic int primeiro(input logic [7:0] r, input int ptr);
    for (int k = 0; k < 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  // One clock edge of the arbitration rules.
  function automatic mstate_t mstep(input mstate_t m, input logic rst,
                                    input logic [7:0] r, input int tmax);
    mstate_t n = m;
    int      w;
    if (rst) begin
      n = '{0, 0, 0, 0};
    end else if (!m.valido) begin
      w = primeiro(r, m.ptr);
      if (w >= 0) n = '{1, w, m.ptr, 1};
    end else if (r[m.sel] && m.cont < tmax) begin
      n.cont = m.cont + 1;
    end else begin
      n.ptr = (m.sel + 1) % 8;
      w     = primeiro(r, n.ptr);
      if (w >= 0) begin
        n.sel  = w;
        n.cont = 1;
      end else begin
        n.valido = 0;
        n.cont   = 0;
      end
    end
    return n;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the models,
  // then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic [7:0] q);
    reset = r;
    req   = q;
    @(posedge clock);
    m_a = mstep(m_a, r, q, 4);
    m_b = mstep(m_b, r, q, 2);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] eg;
    logic [3:0] es;
    eg = m_a.valido ? 8'(1 << m_a.sel) : 8'h00;
    es = m_a.valido ? s[m_a.sel] : 4'h0;
    cmp({tag, "_a_gnt"}, gnt_a, eg);
    cmp({tag, "_a_sel"}, 8'(sel_a), 8'(m_a.sel));
    cmp({tag, "_a_valido"}, 8'(val_a), 8'(m_a.valido));
    cmp({tag, "_a_saida"}, 8'(sai_a), 8'(es));
    cmp({tag, "_a_origem"}, 8'(org_a), m_a.valido ? 8'(m_a.sel) : 8'h00);
    eg = m_b.valido ? 8'(1 << m_b.sel) : 8'h00;
    es = m_b.valido ? s[m_b.sel] : 4'h0;
    cmp({tag, "_b_gnt"}, gnt_b, eg);
    cmp({tag, "_b_sel"}, 8'(sel_b), 8'(m_b.sel));
    cmp({tag, "_b_valido"}, 8'(val_b), 8'(m_b.valido));
    cmp({tag, "_b_saida"}, 8'(sai_b), 8'(es));
    cmp({tag, "_b_origem"}, 8'(org_b), m_b.valido ? 8'(m_b.sel) : 8'h00);
  endtask

  initial begin
    vetor_t tab [14];
    logic   r;
    logic [7:0] q;

    reset = 1'b1;
    req   = 8'h00;
    for (int i = 0; i < 8; i++) s[i] = 4'(i * 3 + 1);
    s[3] = 4'hA;

    // Hand-derived sequence for dut_a (TEMPO_MAX=4): reset with all
    // requesting, single requester with time-limit re-grant, idle,
    // source 7 granted then dropping so source 0 wins, final idle.
    tab[0]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};
    tab[1]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};
    tab[2]  = '{1'b0, 8'hFF, 8'h01, 1'b1, 3'd0};
    tab[3]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[4]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[5]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[6]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[7]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[8]  = '{1'b0, 8'h08, 8'h08, 1'b1, 3'd3};
    tab[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd3};
    tab[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd3};
    tab[11] = '{1'b0, 8'h81, 8'h80, 1'b1, 3'd7};
    tab[12] = '{1'b0, 8'h01, 8'h01, 1'b1, 3'd0};
    tab[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 3'd0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tab[i].rst, tab[i].req);
      cmp($sformatf("tab%0d_gnt", i), gnt_a, tab[i].gnt);
      cmp($sformatf("tab%0d_valido", i), 8'(val_a), 8'(tab[i].valido));
      cmp($sformatf("tab%0d_sel", i), 8'(sel_a), 8'(tab[i].sel));
      cmp($sformatf("tab%0d_saida", i), 8'(sai_a),
          tab[i].valido ? 8'(s[tab[i].sel]) : 8'h00);
      cmp($sformatf("tab%0d_origem", i), 8'(org_a),
          tab[i].valido ? 8'(tab[i].sel) : 8'h00);
      checkOutput($sformatf("tab%0d", i));
    end

    // Rotation on dut_b (TEMPO_MAX=2) with everyone requesting:
    // SEL goes 0,0,1,1,...,7,7 and wraps to 0.
    applyStimulus(1'b1, 8'hFF);
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b0, 8'hFF);
      cmp($sformatf("rot%0d_sel", k), 8'(sel_b), 8'((k / 2) % 8));
      cmp($sformatf("rot%0d_gnt", k), gnt_b, 8'(1 << ((k / 2) % 8)));
      cmp($sformatf("rot%0d_valido", k), 8'(val_b), 8'h01);
      checkOutput($sformatf("rot%0d", k));
    end

    // Reset in the middle of a grant of source 5, then search from 0.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b0, 8'h20);
    applyStimulus(1'b0, 8'h20);
    cmp("mid_sel5", 8'(sel_a), 8'd5);
    applyStimulus(1'b1, 8'h20);
    cmp("mid_rst_gnt", gnt_a, 8'h00);
    cmp("mid_rst_valido", 8'(val_a), 8'h00);
    cmp("mid_rst_sel", 8'(sel_a), 8'h00);
    cmp("mid_rst_saida", 8'(sai_a), 8'h00);
    cmp("mid_rst_origem", 8'(org_a), 8'h00);
    applyStimulus(1'b0, 8'h24);
    cmp("mid_after_gnt", gnt_a, 8'h04);
    cmp("mid_after_sel", 8'(sel_a), 8'd2);
    checkOutput("mid");

    // Randomized traffic against the models.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) s[i] = 4'($urandom);
      r = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 3))
        0:       q = 8'h00;
        1:       q = 8'(1 << $urandom_range(0, 7));
        default: q = 8'($urandom);
      endcase
      applyStimulus(r, q);
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_rr.md
ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 The block SHALL have parameter TEMPO_MAX, default 4, meaning maximum consecutive grant cycles per requester, legal range 1..8.
REQ-002 The block SHALL have port clock, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port REQ, input, 8, where REQ[i] is the request from source i.
REQ-005 The block SHALL have ports S0..S7, input, 4 each, carrying the data of source 0..7.
REQ-006 The block SHALL have port GNT, output, 8, one-hot grant, all zero when no source is granted.
REQ-007 The block SHALL have port SEL, output, 3, the registered index of the granted source.
REQ-008 The block SHALL have port VALIDO, output, 1, high while a grant is active.
REQ-009 The block SHALL have port SAIDA, output, 4, the data of the granted source.
REQ-010 The block SHALL have port ORIGEM, output, 3, equal to SEL while VALIDO is high and 0 otherwise.

Function
REQ-011 The FSM SHALL have two states, OCIOSO (no grant) and CONCEDIDO (one source granted).
REQ-012 Arbitration SHALL be round-robin: the winner is the first i with REQ[i]=1, searching from pointer PTR upward with wrap 7->0.
REQ-013 In OCIOSO with REQ nonzero at an edge, the block SHALL enter CONCEDIDO at that edge, with GNT/SEL set to the winner, VALIDO=1 and CONT=1, giving 1-cycle grant latency.
REQ-014 In OCIOSO with REQ=0, the block SHALL remain in OCIOSO with GNT=0, VALIDO=0 and SEL held.
REQ-015 In CONCEDIDO, the grant SHALL be released at an edge if REQ[SEL]=0 or CONT=TEMPO_MAX; otherwise CONT increments and the grant holds.
REQ-016 On release, PTR SHALL become (SEL+1) mod 8, and arbitration SHALL be re-run at the same edge using the new PTR and current REQ.
REQ-017 On release with a winner, the block SHALL stay in CONCEDIDO with the new winner and CONT=1 (no idle bubble); if the only requester is the releasing source, that source SHALL be re-granted.
REQ-018 On release with no winner, the block SHALL go to OCIOSO with GNT=0 and VALIDO=0.
REQ-019 PTR SHALL change only on release, never while a grant is held.
REQ-020 SAIDA SHALL be the combinational S[SEL] when VALIDO=1, and 4'b0000 otherwise.
REQ-021 GNT SHALL never have more than one bit set, and GNT SHALL equal (1<<SEL) whenever VALIDO=1.
REQ-022 Changes to REQ bits of non-granted sources SHALL NOT affect the current grant.
REQ-023 CONT SHALL be 4 bits wide and SHALL never exceed TEMPO_MAX.

Reset
REQ-024 When reset=1 at an edge, reset SHALL override REQ and the block SHALL set state=OCIOSO, PTR=0, CONT=0, GNT=0, SEL=0, VALIDO=0, hence SAIDA=0 and ORIGEM=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant at that edge, and the first grant after reset SHALL search from source 0.

Structure
REQ-026 A shared package SHALL hold the state enum (OCIOSO, CONCEDIDO), the constant N_FONTES=8 and the index width 3.
REQ-027 The data selection SHALL be a single sub-module, mux8_4b, a combinational 8:1 mux of 4-bit inputs indexed by SEL.
REQ-028 The round-robin search SHALL be a function of (REQ, PTR) returning a found flag and an index.

Verification
REQ-029 Reset scenario: reset=1 with REQ=8'hFF for 2 cycles -> GNT=0, VALIDO=0, SEL=0, SAIDA=0; release reset -> the next edge grants GNT=8'h01.
REQ-030 Single requester scenario: REQ=8'h08 held, S3=4'hA, TEMPO_MAX=4 -> GNT=8'h08, SAIDA=4'hA, ORIGEM=3; at CONT=4 source 3 is re-granted with no VALIDO gap.
REQ-031 Rotation scenario: REQ=8'hFF held, TEMPO_MAX=2 -> SEL sequence is 0,0,1,1,...,7,7,0 with the wrap 7->0 checked.
REQ-032 Early-drop scenario: REQ=8'h81 with source 7 granted, then REQ[7] drops -> source 0 is granted at the next edge, PTR=0.
REQ-033 Idle scenario: the granted source drops while REQ becomes 0 -> next edge GNT=0, VALIDO=0, SAIDA=0, ORIGEM=0.
REQ-034 Mid-grant reset scenario: source 5 granted with CONT=2, then reset pulse -> all outputs 0; with REQ=8'h24 afterward, source 2 is granted first.
